// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen -- serial bit-pattern transmitter
//
// Loads a W-bit pattern and shifts it out MSB-first on x_out, one bit per
// clock. The pattern is repeated a programmable number of times with GAP_CYC
// idle cycles between repeats. Intended to drive the serial input of the
// sequence detector for on-chip exercise of the detector path.
//
// Optional feature macro: SEQ_GEN_ABORT_EN
//   When defined, adds the `abort` input and the `aborted` output. An abort
//   seen in SEND or GAP drops the transfer next cycle and pulses `aborted`.
//
// Ports:
//   clk        in   1   system clock, all logic on posedge
//   rst        in   1   synchronous active-low reset
//   start      in   1   begin a transfer (only looked at in IDLE)
//   pat_in     in   W   pattern to send, bit W-1 first
//   reps       in   RW  number of transmissions, 0 behaves as 1
//   abort      in   1   (SEQ_GEN_ABORT_EN only) drop the current transfer
//   x_out      out  1   serial line, idles at 1
//   valid      out  1   x_out carries a pattern bit
//   busy       out  1   transfer in progress (through the DONE cycle)
//   done       out  1   one-cycle pulse after the last bit of the last repeat
//   aborted    out  1   (SEQ_GEN_ABORT_EN only) one-cycle pulse after abort
//   fsm_state  out  2   current FSM state (IDLE=0, SEND=1, GAP=2, DONE=3)
//
// Handshake: start is a level request; it is accepted on any posedge where the
// FSM is IDLE and start=1. There is no ready output: busy=0 means the next
// start will be taken. Starts while busy are dropped, never queued.
// -----------------------------------------------------------------------------
module seq_gen #(
    parameter int W       = 3,
    parameter int RW      = 4,
    parameter int GAP_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  pat_in,
    input  logic [RW-1:0] reps,
`ifdef SEQ_GEN_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    output logic          x_out,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic [1:0]    fsm_state
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic [W-1:0]  shift;     // shift[W-1] is the bit currently on x_out
    logic [W-1:0]  pat_lat;   // latched copy for reloading on each repeat
    logic [RW-1:0] rem;       // repeats still to finish, including current one
    logic [BW-1:0] bit_cnt;   // bits left after the one currently on x_out
    logic [GW-1:0] gap_cnt;   // gap cycles left after the current one
    logic          abort_req;

`ifdef SEQ_GEN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            shift   <= '0;
            pat_lat <= '0;
            rem     <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            x_out   <= 1'b1;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SEQ_GEN_ABORT_EN
            aborted <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef SEQ_GEN_ABORT_EN
            aborted <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    x_out <= 1'b1;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    if (start) begin
                        shift   <= pat_in;
                        pat_lat <= pat_in;
                        rem     <= (reps == '0) ? RW'(1) : reps;
                        bit_cnt <= BW'(W - 1);
                        x_out   <= pat_in[W-1];
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= SEND;
                    end
                end

                SEND: begin
                    if (abort_req) begin
                        state <= IDLE;
                        x_out <= 1'b1;
                        valid <= 1'b0;
                        busy  <= 1'b0;
`ifdef SEQ_GEN_ABORT_EN
                        aborted <= 1'b1;
`endif
                    end else if (bit_cnt != '0) begin
                        shift   <= {shift[W-2:0], 1'b0};
                        x_out   <= shift[W-2];
                        bit_cnt <= bit_cnt - BW'(1);
                    end else begin
                        // Bit 0 is on the line now: this repeat is finished.
                        rem <= rem - RW'(1);
                        if (rem == RW'(1)) begin
                            state <= DONE;
                            x_out <= 1'b1;
                            valid <= 1'b0;
                            done  <= 1'b1;
                        end else if (GAP_CYC > 0) begin
                            state   <= GAP;
                            gap_cnt <= GW'(GAP_CYC - 1);
                            x_out   <= 1'b1;
                            valid   <= 1'b0;
                        end else begin
                            // No gap: restart the pattern with no bubble.
                            shift   <= pat_lat;
                            x_out   <= pat_lat[W-1];
                            bit_cnt <= BW'(W - 1);
                        end
                    end
                end

                GAP: begin
                    if (abort_req) begin
                        state <= IDLE;
                        x_out <= 1'b1;
                        valid <= 1'b0;
                        busy  <= 1'b0;
`ifdef SEQ_GEN_ABORT_EN
                        aborted <= 1'b1;
`endif
                    end else if (gap_cnt == '0) begin
                        shift   <= pat_lat;
                        x_out   <= pat_lat[W-1];
                        valid   <= 1'b1;
                        bit_cnt <= BW'(W - 1);
                        state   <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                    x_out <= 1'b1;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    x_out <= 1'b1;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_gen -- bench for seq_gen
//
// Two instances share stimulus: dut_a uses GAP_CYC=2, dut_b uses GAP_CYC=0.
// Expected per-cycle outputs {x_out, valid, busy, done} come from a model that
// lists what the line should carry for a given pattern and repeat count.
// -----------------------------------------------------------------------------
module tb_seq_gen;

    localparam int W  = 3;
    localparam int RW = 4;
    localparam int GAP_A = 2;
    localparam int GAP_B = 0;
    localparam logic [3:0] IDLE_OUT = 4'b1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  pat_in;
    logic [RW-1:0] reps;
    logic          a_x, a_v, a_b, a_d;
    logic          b_x, b_v, b_b, b_d;
    logic [1:0]    a_st, b_st;
`ifdef SEQ_GEN_ABORT_EN
    logic          abort;
    logic          a_ab, b_ab;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_a[$];
    logic [3:0] exp_b[$];

    // clock / reset
    always #5 clk = ~clk;

    seq_gen #(.W(W), .RW(RW), .GAP_CYC(GAP_A)) dut_a (
        .clk(clk), .rst(rst), .start(start), .pat_in(pat_in), .reps(reps),
`ifdef SEQ_GEN_ABORT_EN
        .abort(abort), .aborted(a_ab),
`endif
        .x_out(a_x), .valid(a_v), .busy(a_b), .done(a_d), .fsm_state(a_st)
    );

    seq_gen #(.W(W), .RW(RW), .GAP_CYC(GAP_B)) dut_b (
        .clk(clk), .rst(rst), .start(start), .pat_in(pat_in), .reps(reps),
`ifdef SEQ_GEN_ABORT_EN
        .abort(abort), .aborted(b_ab),
`endif
        .x_out(b_x), .valid(b_v), .busy(b_b), .done(b_d), .fsm_state(b_st)
    );

    // Reference: n repeats of the pattern MSB-first, gaps between repeats,
    // a done cycle, then one idle cycle.
    task automatic model_push(input logic [W-1:0] pat, input int r, input int gap, input bit sel);
        int n;
        logic [3:0] e[$];
        n = (r == 0) ? 1 : r;
        for (int k = 0; k < n; k++) begin
            for (int i = W - 1; i >= 0; i--) e.push_back({pat[i], 1'b1, 1'b1, 1'b0});
            if (k < n - 1)
                for (int g = 0; g < gap; g++) e.push_back(4'b1010);
        end
        e.push_back(4'b1011);
        e.push_back(IDLE_OUT);
        foreach (e[j]) begin
            if (sel) exp_b.push_back(e[j]);
            else     exp_a.push_back(e[j]);
        end
    endtask

    task automatic push_both(input logic [W-1:0] pat, input int r);
        model_push(pat, r, GAP_A, 1'b0);
        model_push(pat, r, GAP_B, 1'b1);
    endtask

    // driver + scoreboard: starts a transfer at the current negedge and checks
    // every following cycle until both expected queues drain.
    // kill_kind: 0 = reset at kill_at, 1 = abort at kill_at.
    task automatic run_xfer(input logic [W-1:0] pat, input int r, input int hold_cycles,
                            input int ignore_at, input int kill_at, input int kill_kind,
                            input string tag);
        int cyc;
        logic [3:0] ea, eb;
        cyc    = 0;
        start  = 1'b1;
        pat_in = pat;
        reps   = RW'(r);
        while ((exp_a.size() > 0 || exp_b.size() > 0) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            ea = (exp_a.size() > 0) ? exp_a.pop_front() : IDLE_OUT;
            eb = (exp_b.size() > 0) ? exp_b.pop_front() : IDLE_OUT;
            checks++;
            if ({a_x, a_v, a_b, a_d} !== ea) begin
                errors++;
                $display("FAIL %s dut_a cycle %0d: x/valid/busy/done got %b expected %b",
                         tag, cyc, {a_x, a_v, a_b, a_d}, ea);
            end
            checks++;
            if ({b_x, b_v, b_b, b_d} !== eb) begin
                errors++;
                $display("FAIL %s dut_b cycle %0d: x/valid/busy/done got %b expected %b",
                         tag, cyc, {b_x, b_v, b_b, b_d}, eb);
            end
`ifdef SEQ_GEN_ABORT_EN
            checks++;
            if ({a_ab, b_ab} !== {2{kill_kind == 1 && cyc == kill_at + 1}}) begin
                errors++;
                $display("FAIL %s aborted cycle %0d: got %b%b expected %b",
                         tag, cyc, a_ab, b_ab, (kill_kind == 1 && cyc == kill_at + 1));
            end
`endif
            // drive inputs for the next posedge
            if (cyc == hold_cycles || cyc == ignore_at + 1) start = 1'b0;
            if (cyc == ignore_at) begin
                start  = 1'b1;
                pat_in = '1;
            end else if (!start) begin
                pat_in = W'($urandom);
                reps   = RW'($urandom);
            end
            if (cyc == kill_at) begin
                if (kill_kind == 0) rst = 1'b0;
`ifdef SEQ_GEN_ABORT_EN
                else abort = 1'b1;
`endif
                exp_a.delete();
                exp_b.delete();
                repeat (2) begin
                    exp_a.push_back(IDLE_OUT);
                    exp_b.push_back(IDLE_OUT);
                end
            end
            if (cyc == kill_at + 1) begin
                rst = 1'b1;
`ifdef SEQ_GEN_ABORT_EN
                abort = 1'b0;
`endif
            end
        end
        start = 1'b0;
        if (cyc >= 400) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: cycles %0d expected under 400", tag, cyc);
            exp_a.delete();
            exp_b.delete();
        end
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        start  = 1'b1;
        pat_in = '0;
        reps   = '0;
`ifdef SEQ_GEN_ABORT_EN
        abort  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_x, a_v, a_b, a_d, b_x, b_v, b_b, b_d} !== {IDLE_OUT, IDLE_OUT}) begin
            errors++;
            $display("FAIL reset: outputs got %b expected %b",
                     {a_x, a_v, a_b, a_d, b_x, b_v, b_b, b_d}, {IDLE_OUT, IDLE_OUT});
        end
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_x, a_v, a_b, a_d, b_x, b_v, b_b, b_d} !== {IDLE_OUT, IDLE_OUT}) begin
            errors++;
            $display("FAIL reset_release: outputs got %b expected %b",
                     {a_x, a_v, a_b, a_d, b_x, b_v, b_b, b_d}, {IDLE_OUT, IDLE_OUT});
        end
    endtask

    task automatic test_single();
        push_both(3'b001, 1);
        run_xfer(3'b001, 1, 1, -5, -5, 0, "single");
    endtask

    task automatic test_gap_repeats();
        push_both(3'b001, 3);
        run_xfer(3'b001, 3, 1, -5, -5, 0, "gap_repeats");
    endtask

    task automatic test_back_to_back();
        push_both(3'b101, 0);
        run_xfer(3'b101, 0, 1, -5, -5, 0, "reps_zero");
        push_both(3'b101, 2);
        run_xfer(3'b101, 2, 1, -5, -5, 0, "back_to_back");
    endtask

    task automatic test_ignore_start();
        push_both(3'b001, 1);
        run_xfer(3'b001, 1, 1, 2, -5, 0, "ignore_start");
        // begins in the cycle right after DONE
        push_both(3'b110, 1);
        run_xfer(3'b110, 1, 1, -5, -5, 0, "start_after_done");
    endtask

    task automatic test_reset_mid();
        push_both(3'b011, 3);
        run_xfer(3'b011, 3, 1, -5, 2, 0, "reset_mid");
        push_both(3'b010, 2);
        run_xfer(3'b010, 2, 1, -5, -5, 0, "after_reset");
    endtask

    task automatic test_max_reps();
        logic [W-1:0] p;
        p = W'($urandom);
        push_both(p, 15);
        run_xfer(p, 15, 1, -5, -5, 0, "max_reps");
    endtask

    task automatic test_held_start();
        // reps=1 keeps both instances in step; three transfers of 5 cycles each
        repeat (3) push_both(3'b110, 1);
        run_xfer(3'b110, 1, 11, -5, -5, 0, "held_start");
    endtask

    task automatic test_random();
        logic [W-1:0] p;
        int r;
        for (int i = 0; i < 10; i++) begin
            p = W'($urandom);
            r = $urandom_range(0, 6);
            push_both(p, r);
            run_xfer(p, r, 1, -5, -5, 0, "random");
        end
    endtask

`ifdef SEQ_GEN_ABORT_EN
    task automatic test_abort();
        push_both(3'b001, 3);
        run_xfer(3'b001, 3, 1, -5, 4, 1, "abort_gap");
        push_both(3'b100, 1);
        run_xfer(3'b100, 1, 1, -5, -5, 0, "after_abort");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_gap_repeats();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_max_reps();
        test_held_start();
        test_random();
`ifdef SEQ_GEN_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Serial bit-pattern transmitter. It is the transmit-side counterpart of the serial sequence detector.
- Loads a W-bit pattern and emits it MSB-first on a single serial line, one bit per clock. The pattern is repeated a programmable number of times, with an idle gap between repeats.
- Drives the detector's serial input `x`. Used to stimulate and exercise the detector path on-chip.

Parameters:
- W, 3: pattern width in bits (>=2).
- RW, 4: width of the repeat-count input.
- GAP_CYC, 2: idle cycles inserted between consecutive repeats. 0 means repeats are sent back-to-back.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- start  in  1  request to begin a transfer; sampled only in IDLE.
- pat_in  in  W  pattern to send; bit W-1 is sent first.
- reps  in  RW  number of pattern transmissions; 0 is treated as 1.
- x_out  out  1  serial data line; idle level is 1.
- valid  out  1  high while x_out carries a pattern bit (not during the gap or idle).
- busy  out  1  high from the cycle after start is accepted until the cycle after done.
- done  out  1  one-cycle pulse after the final bit of the final repeat.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at posedge):
  - state=IDLE; x_out=1, valid=0, busy=0, done=0.
  - Internal shift register, bit counter, repeat counter and gap counter cleared.
  - Reset mid-transfer aborts immediately; no done pulse.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - x_out=1, valid=0, busy=0.
  - start=1 at edge T: latch pat_in into the shift register; latch rem = (reps==0 ? 1 : reps); go to SEND.
  - In cycle T+1: x_out = pat_in[W-1], valid=1, busy=1.
- SEND:
  - One bit per cycle, MSB first; bit i of the latched pattern appears in cycle T+1+(W-1-i).
  - When the last bit (bit 0) has been driven, rem decrements:
    - If rem becomes 0: go to DONE.
    - Else if GAP_CYC>0: go to GAP.
    - Else: reload the latched pattern and send bit W-1 in the very next cycle (no bubble).
- GAP:
  - x_out=1, valid=0, busy=1 for exactly GAP_CYC cycles.
  - Then SEND restarts with bit W-1 of the same latched pattern.
- DONE:
  - One cycle with done=1, x_out=1, valid=0, busy=1; then IDLE with busy=0.
  - The earliest next start is accepted in the cycle after DONE.
- Latency:
  - First bit 1 cycle after start accepted.
  - Total busy cycles = reps*W + (reps-1)*GAP_CYC + 1.
- Boundary conditions:
  - start while busy: ignored, not queued.
  - pat_in and reps changes during a transfer: no effect (latched copies used).
  - reps = 2^RW-1: counter must not wrap early.
  - start held high continuously: a new transfer begins each time IDLE is entered.

Optional Feature:
- Macro SEQ_GEN_ABORT_EN.
- Defined:
  - Adds input `abort` (1 bit) and output `aborted` (1 bit, registered, reset 0).
  - abort=1 sampled in SEND or GAP: next cycle state=IDLE, x_out=1, valid=0, busy=0, aborted=1 for one cycle, done stays 0.
  - abort in IDLE or DONE is ignored. DONE completes normally.
  - abort and rst=0 together: reset wins; aborted=0.
- Undefined: neither port exists; behaviour exactly as above.

Test Plan:
- Single pattern: rst=0 two cycles, then pat_in=3'b001, reps=1, start pulse → x_out 0,0,1 with valid=1 in cycles T+1..T+3; done=1 at T+4; busy low at T+5; detector fed by x_out asserts z when the final 1 is present.
- Repeats with gap: pat_in=3'b001, reps=3, GAP_CYC=2 → x_out 0,0,1,1,1,0,0,1,1,1,0,0,1; valid pattern 111 00 111 00 111; done at T+14.
- reps=0 and back-to-back: pat_in=3'b101, reps=0, GAP_CYC=0 → exactly one pattern 1,0,1; then reps=2 → 1,0,1,1,0,1 with no idle bit between repeats.
- Ignore start while busy: start pulsed again at T+2 with pat_in=3'b111 → original pattern unaffected, no second transfer; start at DONE+1 is accepted.
- Reset mid-transfer: rst=0 at T+2 → next cycle x_out=1, valid=0, busy=0, done never pulses; a fresh start after reset transmits correctly.
- With SEQ_GEN_ABORT_EN: abort=1 during the GAP of a reps=3 transfer → next cycle IDLE, aborted=1 for one cycle, done=0; rebuild without the macro and confirm the port is absent and the baseline tests pass.
